centroid_div_seq: RTL and testbench
===================================

# centroid_div_seq

Multi-cycle division sequencer for the red-object centroid path. At end of frame it accepts the frame's accumulated statistics and shares one iterative restoring divider between the X and Y centroid quotients, computing X first and then Y. It also evaluates the density/size qualification and presents a registered result with a one-cycle valid strobe to downstream overlay/tracking logic. This removes wide combinational dividers from the frame-statistics datapath.

## Interface
- IMG_WIDTH, 640, horizontal resolution; X quotient saturates to IMG_WIDTH-1
- IMG_HEIGHT, 480, vertical resolution; Y quotient saturates to IMG_HEIGHT-1
- PIXEL_THRESHOLD, 1000, minimum red pixel count for a valid object
- DENSITY_THRESHOLD, 40, minimum fill of bounding box, integer percent
- i_clk  in  1  single clock
- i_rst  in  1  synchronous, active-high reset
- i_start  in  1  one-cycle frame-done strobe; operands sampled on the same edge
- i_red_count  in  19  red pixel count (divisor)
- i_sum_x  in  32  sum of red pixel X positions
- i_sum_y  in  32  sum of red pixel Y positions
- i_box_w  in  11  bounding box width, 1..IMG_WIDTH
- i_box_h  in  10  bounding box height, 1..IMG_HEIGHT
- o_busy  out  1  high while state != IDLE
- o_overrun  out  1  one-cycle pulse when i_start arrives while busy
- centroid_x  out  10  registered X centroid
- centroid_y  out  9  registered Y centroid
- red_object_valid  out  1  registered qualification result
- valid  out  1  one-cycle pulse when a new centroid is published

## Operation
- States: IDLE, DIV_X, DIV_Y, DONE.
- IDLE + i_start, i_red_count != 0: latch count, sum_x, sum_y, box_w, box_h; clear remainder; load the 32-bit dividend register with sum_x; bit counter = 31; go to DIV_X.
- IDLE + i_start, i_red_count == 0: no division; on the next edge centroid_x = 0, centroid_y = 0, red_object_valid = 0, valid stays 0; busy for exactly that one cycle.
- Divider: restoring, MSB first, one quotient bit per cycle.
  - rem' = {rem[18:0], dividend[31]}, using a 20-bit remainder.
  - If rem' >= count: subtract count and set the quotient bit to 1; otherwise set it to 0.
  - Shift the dividend left by one.
- DIV_X: 32 iterations; on the last iteration store qx, reload the dividend with the latched sum_y, reset remainder and counter, go to DIV_Y.
- DIV_Y: 32 iterations; store qy, go to DONE.
- DONE (one cycle):
  - centroid_x = min(qx, IMG_WIDTH-1); centroid_y = min(qy, IMG_HEIGHT-1).
  - red_object_valid = (count*100 >= box_w*box_h*DENSITY_THRESHOLD) && (count >= PIXEL_THRESHOLD). Both products are 32-bit unsigned.
  - valid = 1; go to IDLE.
- The density compare may be registered during DIV_X; it is published only in DONE.
- Outputs hold their last values until the next DONE or zero-count clear.
- i_start while o_busy: ignored; latched operands are untouched; o_overrun = 1 for one cycle.

## Timing
- Reset values: o_busy 0, o_overrun 0, centroid_x 0, centroid_y 0, red_object_valid 0, valid 0, state IDLE.
- Reset mid-operation aborts the division with no valid pulse; reset dominates a simultaneous i_start.
- i_start sampled at edge E0. DIV_X occupies E1..E32 and DIV_Y E33..E64. DONE at E65 writes the outputs, and valid is high for the cycle after E65.
- Total latency: 65 cycles from the sampling edge to the output update.
- o_busy is high after E0 through E64 and low after E65. A new i_start in the cycle where valid is high is accepted.
- Zero-count path: outputs cleared at E1; o_busy high only between E0 and E1.
- Minimum start spacing is 66 cycles, far below one frame.

## Test plan
- count=1200, sum_x=384000, sum_y=288000, box 40x40: valid pulses exactly 65 edges after start, centroid (320,240), red_object_valid=1 (120000 >= 64000).
- count=3, sum_x=10, sum_y=8, box 2x2: centroid (3,2) by truncation, red_object_valid=0 (count < 1000).
- Density boundary, count=1000, box 50x50: 100000 >= 100000 gives red_object_valid=1. Same with box 50x51: red_object_valid=0.
- count=0: no valid pulse; centroid_x, centroid_y and red_object_valid cleared one edge after start; o_busy high for exactly one cycle.
- Second i_start 10 cycles after the first: o_overrun pulses once and the first result is unchanged. Reset at cycle 30 of a run: o_busy=0, all outputs 0, no valid; a following start completes normally.
- count=1, sum_x=1000, sum_y=600: centroid saturates to (639,479).

Source files
------------

// File: rtl/centroid_div_seq.sv
// Frame-end centroid sequencer: one shared restoring divider computes X then Y
// centroids, then publishes saturated centroids and the density/size qualification.
module centroid_div_seq #(
  parameter int unsigned IMG_WIDTH         = 640,
  parameter int unsigned IMG_HEIGHT        = 480,
  parameter int unsigned PIXEL_THRESHOLD   = 1000,
  parameter int unsigned DENSITY_THRESHOLD = 40
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [18:0] i_red_count,
  input  logic [31:0] i_sum_x,
  input  logic [31:0] i_sum_y,
  input  logic [10:0] i_box_w,
  input  logic [9:0]  i_box_h,
  output logic        o_busy,
  output logic        o_overrun,
  output logic [9:0]  centroid_x,
  output logic [8:0]  centroid_y,
  output logic        red_object_valid,
  output logic        valid
);

  localparam logic [31:0] XMax = 32'(IMG_WIDTH - 1);
  localparam logic [31:0] YMax = 32'(IMG_HEIGHT - 1);

  typedef enum logic [1:0] {StIdle, StDivX, StDivY, StDone} state_e;

  state_e      state_q, state_d;
  logic [18:0] count_q;
  logic [31:0] sum_y_q;
  logic [10:0] box_w_q;
  logic [9:0]  box_h_q;
  logic [31:0] dividend_q;
  // Stored remainder is always < count, so 19 bits hold it; the shifted value is 20 bits.
  logic [18:0] rem_q;
  logic [31:0] quot_q;
  logic [31:0] qx_q;
  logic [4:0]  bit_cnt_q;
  logic        zero_q;
  logic        dense_q;
  logic        overrun_q;
  logic [9:0]  cx_q;
  logic [8:0]  cy_q;
  logic        obj_q;
  logic        valid_q;

  logic [19:0] rem_shift;
  logic [19:0] rem_next;
  logic        q_bit;
  logic [31:0] quot_next;
  logic        last;
  logic [31:0] prod_cnt;
  logic [31:0] prod_box;

  always_comb begin
    rem_shift = {rem_q, dividend_q[31]};
    q_bit     = rem_shift >= {1'b0, count_q};
    rem_next  = q_bit ? (rem_shift - {1'b0, count_q}) : rem_shift;
    quot_next = {quot_q[30:0], q_bit};
    last      = (bit_cnt_q == 5'd0);
    prod_cnt  = 32'(count_q) * 32'd100;
    prod_box  = 32'(box_w_q) * 32'(box_h_q) * DENSITY_THRESHOLD;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (i_start) state_d = (i_red_count != 19'd0) ? StDivX : StDone;
      StDivX: if (last) state_d = StDivY;
      StDivY: if (last) state_d = StDone;
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      count_q    <= '0;
      sum_y_q    <= '0;
      box_w_q    <= '0;
      box_h_q    <= '0;
      dividend_q <= '0;
      rem_q      <= '0;
      quot_q     <= '0;
      qx_q       <= '0;
      bit_cnt_q  <= '0;
      zero_q     <= 1'b0;
      dense_q    <= 1'b0;
      overrun_q  <= 1'b0;
      cx_q       <= '0;
      cy_q       <= '0;
      obj_q      <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      overrun_q <= i_start && (state_q != StIdle);
      valid_q   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (i_start) begin
            count_q    <= i_red_count;
            sum_y_q    <= i_sum_y;
            box_w_q    <= i_box_w;
            box_h_q    <= i_box_h;
            dividend_q <= i_sum_x;
            rem_q      <= '0;
            quot_q     <= '0;
            bit_cnt_q  <= 5'd31;
            zero_q     <= (i_red_count == 19'd0);
          end
        end
        StDivX: begin
          dense_q <= (prod_cnt >= prod_box);
          if (last) begin
            qx_q       <= quot_next;
            dividend_q <= sum_y_q;
            rem_q      <= '0;
            quot_q     <= '0;
            bit_cnt_q  <= 5'd31;
          end else begin
            dividend_q <= {dividend_q[30:0], 1'b0};
            rem_q      <= rem_next[18:0];
            quot_q     <= quot_next;
            bit_cnt_q  <= bit_cnt_q - 5'd1;
          end
        end
        StDivY: begin
          dividend_q <= {dividend_q[30:0], 1'b0};
          rem_q      <= rem_next[18:0];
          quot_q     <= quot_next;
          bit_cnt_q  <= bit_cnt_q - 5'd1;
        end
        StDone: begin
          if (zero_q) begin
            cx_q  <= '0;
            cy_q  <= '0;
            obj_q <= 1'b0;
          end else begin
            cx_q    <= (qx_q > XMax) ? XMax[9:0] : qx_q[9:0];
            cy_q    <= (quot_q > YMax) ? YMax[8:0] : quot_q[8:0];
            obj_q   <= dense_q && (32'(count_q) >= PIXEL_THRESHOLD);
            valid_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_busy           = (state_q != StIdle);
  assign o_overrun        = overrun_q;
  assign centroid_x       = cx_q;
  assign centroid_y       = cy_q;
  assign red_object_valid = obj_q;
  assign valid            = valid_q;

endmodule

// File: tb/tb_centroid_div_seq.sv
// Scoreboard bench for centroid_div_seq: directed vectors push expected results,
// a negedge monitor pops and compares on each valid strobe.
module tb_centroid_div_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [18:0] red_count;
  logic [31:0] sum_x, sum_y;
  logic [10:0] box_w;
  logic [9:0]  box_h;
  logic        busy, overrun;
  logic [9:0]  cx;
  logic [8:0]  cy;
  logic        obj, vld;

  always #5 clk = ~clk;

  centroid_div_seq dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_start         (start),
    .i_red_count     (red_count),
    .i_sum_x         (sum_x),
    .i_sum_y         (sum_y),
    .i_box_w         (box_w),
    .i_box_h         (box_h),
    .o_busy          (busy),
    .o_overrun       (overrun),
    .centroid_x      (cx),
    .centroid_y      (cy),
    .red_object_valid(obj),
    .valid           (vld)
  );

  typedef struct packed {
    logic [9:0] cx;
    logic [8:0] cy;
    logic       obj;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  // Monitor: every valid strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (vld === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL unexpected_valid: got valid=1, expected no pulse");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("centroid_x", 32'(cx), 32'(e.cx));
        check("centroid_y", 32'(cy), 32'(e.cy));
        check("red_object_valid", 32'(obj), 32'(e.obj));
      end
    end
  end

  // Called at #1 after a posedge; returns #1 after the sampling edge E0.
  task automatic issue(input logic [18:0] c, input logic [31:0] sx, input logic [31:0] sy,
                       input logic [10:0] w, input logic [9:0] h);
    red_count = c;
    sum_x     = sx;
    sum_y     = sy;
    box_w     = w;
    box_h     = h;
    start     = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // k0 = edges already elapsed since E0.
  task automatic wait_valid(input string name, input int k0);
    int k;
    k = k0;
    do begin
      @(posedge clk);
      #1 k++;
      if (k == 64) check({name, "_busy_e64"}, 32'(busy), 32'd1);
    end while (vld !== 1'b1 && k < 100);
    check({name, "_latency"}, 32'(k), 32'd65);
    check({name, "_busy_after"}, 32'(busy), 32'd0);
  endtask

  task automatic run_vec(input string name, input logic [18:0] c, input logic [31:0] sx,
                         input logic [31:0] sy, input logic [10:0] w, input logic [9:0] h,
                         input logic [9:0] ecx, input logic [8:0] ecy, input logic eobj);
    exp_t e;
    e.cx  = ecx;
    e.cy  = ecy;
    e.obj = eobj;
    exp_q.push_back(e);
    issue(c, sx, sy, w, h);
    wait_valid(name, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0;
    red_count = '0; sum_x = '0; sum_y = '0; box_w = '0; box_h = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_cx", 32'(cx), 32'd0);
    check("rst_cy", 32'(cy), 32'd0);
    check("rst_obj", 32'(obj), 32'd0);
    check("rst_valid", 32'(vld), 32'd0);

    run_vec("nominal", 19'd1200, 32'd384000, 32'd288000, 11'd40, 10'd40, 10'd320, 9'd240, 1'b1);
    run_vec("small", 19'd3, 32'd10, 32'd8, 11'd2, 10'd2, 10'd3, 9'd2, 1'b0);
    run_vec("dens_eq", 19'd1000, 32'd100000, 32'd50000, 11'd50, 10'd50, 10'd100, 9'd50, 1'b1);
    run_vec("dens_lt", 19'd1000, 32'd100000, 32'd50000, 11'd50, 10'd51, 10'd100, 9'd50, 1'b0);
    run_vec("saturate", 19'd1, 32'd1000, 32'd600, 11'd1, 10'd1, 10'd639, 9'd479, 1'b0);
    run_vec("edge_max", 19'd7, 32'd4473, 32'd3353, 11'd1, 10'd1, 10'd639, 9'd479, 1'b0);
    run_vec("wide_div", 19'd524287, 32'hFFFF_FFFF, 32'd157286100, 11'd1, 10'd1,
            10'd639, 9'd300, 1'b1);
    run_vec("nominal2", 19'd1200, 32'd384000, 32'd288000, 11'd40, 10'd40, 10'd320, 9'd240, 1'b1);

    // Zero count clears the previous non-zero result one edge after start.
    issue(19'd0, 32'd5, 32'd5, 11'd1, 10'd1);
    check("zero_busy_e0", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    check("zero_busy_e1", 32'(busy), 32'd0);
    check("zero_cx", 32'(cx), 32'd0);
    check("zero_cy", 32'(cy), 32'd0);
    check("zero_obj", 32'(obj), 32'd0);
    check("zero_valid", 32'(vld), 32'd0);
    repeat (5) @(posedge clk);
    #1;

    // Overrun: a second start 10 edges in must not disturb the first result.
    begin
      exp_t e;
      e.cx = 10'd100; e.cy = 9'd200; e.obj = 1'b1;
      exp_q.push_back(e);
      issue(19'd1500, 32'd150000, 32'd300000, 11'd30, 10'd30);
      repeat (9) @(posedge clk);
      #1;
      red_count = 19'd1; sum_x = 32'd7; sum_y = 32'd9; box_w = 11'd3; box_h = 10'd3;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      check("overrun_pulse", 32'(overrun), 32'd1);
      @(posedge clk);
      #1;
      check("overrun_clear", 32'(overrun), 32'd0);
      wait_valid("overrun", 11);
    end

    // Reset 30 edges into a run: aborts, clears outputs, no valid afterwards.
    issue(19'd1200, 32'd384000, 32'd288000, 11'd40, 10'd40);
    repeat (29) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_cx", 32'(cx), 32'd0);
    check("abort_cy", 32'(cy), 32'd0);
    check("abort_obj", 32'(obj), 32'd0);
    check("abort_valid", 32'(vld), 32'd0);
    repeat (70) @(posedge clk);
    #1;
    check("abort_idle", 32'(busy), 32'd0);
    run_vec("post_reset", 19'd3, 32'd10, 32'd8, 11'd2, 10'd2, 10'd3, 9'd2, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
